// File: rtl/axis_deadlock_monitor_if.sv
// Stall/idle inputs and block/info outputs of the AXIS deadlock monitor.
// master : stall-detector side, drives axis_block_sigs / inst_idle_sigs.
// slave  : monitor side, drives axis_block_info / block.
interface axis_deadlock_monitor_if #(
  parameter int unsigned NUM_AXIS = 3
);
  logic [NUM_AXIS-1:0]          axis_block_sigs;
  logic [NUM_AXIS-1:0]          inst_idle_sigs;
  logic [NUM_AXIS*NUM_AXIS-1:0] axis_block_info;
  logic                         block;

  modport master (
    output axis_block_sigs,
    output inst_idle_sigs,
    input  axis_block_info,
    input  block
  );

  modport slave (
    input  axis_block_sigs,
    input  inst_idle_sigs,
    output axis_block_info,
    output block
  );
endinterface

// File: rtl/axis_deadlock_monitor.sv
// Per-instance AXI-Stream deadlock monitor over NUM_AXIS channels.
// A channel is declared stalled once its non-idle stall indication persists
// for max(threshold,1) consecutive edges. The monitor raises block while any
// channel is declared, records the first declared channel and counts
// WATCH->DETECTED events.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   clear             synchronous soft clear of counters, flags and capture
//   mon (slave)       axis_block_sigs / inst_idle_sigs in, axis_block_info / block out
//   threshold         persistence threshold, sampled every cycle
//   first_valid       first_idx holds a capture
//   first_idx         lowest channel declared on the first detection
//   event_count       saturating count of WATCH->DETECTED transitions
//
// Build option: define AXIS_DEADLOCK_STICKY_EN to latch detection (block,
// declarations and info slices) until reset or clear.
module axis_deadlock_monitor #(
  parameter int unsigned NUM_AXIS = 3,
  parameter int unsigned THRESH_W = 8,
  parameter int unsigned EVT_W    = 16,
  parameter int unsigned IDX_W    = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  axis_deadlock_monitor_if.slave     mon,
  input  logic [THRESH_W-1:0]        threshold,
  output logic                       first_valid,
  output logic [IDX_W-1:0]           first_idx,
  output logic [EVT_W-1:0]           event_count
);

  localparam int unsigned INFO_W = NUM_AXIS * NUM_AXIS;
  localparam int unsigned CMP_W  = THRESH_W + 1;

  typedef enum logic {
    ST_WATCH    = 1'b0,
    ST_DETECTED = 1'b1
  } state_e;

  state_e                             state_q, state_d;
  logic [NUM_AXIS-1:0][THRESH_W-1:0]  cnt_q, cnt_d;
  logic [NUM_AXIS-1:0]                decl_q, decl_d;
  logic [INFO_W-1:0]                  info_q, info_d;
  logic [EVT_W-1:0]                   evt_q, evt_d;
  logic                               fv_q, fv_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;

  logic [THRESH_W-1:0]                thr_eff;
  logic [NUM_AXIS-1:0]                act;
  logic [NUM_AXIS-1:0]                decl_new;
  logic                               rise;
  logic [IDX_W-1:0]                   low_idx;

  // Next-state computation for counters, declarations, FSM and capture.
  always_comb begin
    thr_eff  = (threshold == '0) ? THRESH_W'(1) : threshold;
    act      = mon.axis_block_sigs & ~mon.inst_idle_sigs;
    cnt_d    = '0;
    decl_new = '0;
    for (int k = 0; k < int'(NUM_AXIS); k++) begin
      if (act[k]) begin
        cnt_d[k] = (cnt_q[k] == '1) ? cnt_q[k] : cnt_q[k] + THRESH_W'(1);
      end
      // Compare one bit wider so cnt+1 cannot wrap at saturation.
      decl_new[k] = act[k] &&
                    ((CMP_W'(cnt_q[k]) + CMP_W'(1)) >= CMP_W'(thr_eff));
    end

`ifdef AXIS_DEADLOCK_STICKY_EN
    decl_d = decl_new | decl_q;
`else
    decl_d = decl_new;
`endif

    state_d = state_q;
    case (state_q)
      ST_WATCH:    if (|decl_d) state_d = ST_DETECTED;
`ifdef AXIS_DEADLOCK_STICKY_EN
      ST_DETECTED: state_d = ST_DETECTED;
`else
      ST_DETECTED: if (~|decl_d) state_d = ST_WATCH;
`endif
      default:     state_d = ST_WATCH;
    endcase

    rise = (state_q == ST_WATCH) && (|decl_d);

    evt_d = evt_q;
    if (rise && (evt_q != '1)) evt_d = evt_q + EVT_W'(1);

    // Lowest declared index: scan downward so the smallest k wins.
    low_idx = '0;
    for (int k = int'(NUM_AXIS) - 1; k >= 0; k--) begin
      if (decl_d[k]) low_idx = IDX_W'(k);
    end

    fv_d  = fv_q;
    idx_d = idx_q;
    if (rise && !fv_q) begin
      fv_d  = 1'b1;
      idx_d = low_idx;
    end

    info_d = '0;
    for (int k = 0; k < int'(NUM_AXIS); k++) begin
      if (decl_d[k]) info_d[k*NUM_AXIS +: NUM_AXIS] = ~(NUM_AXIS'(1) << k);
    end

    if (clear) begin
      state_d = ST_WATCH;
      cnt_d   = '0;
      decl_d  = '0;
      info_d  = '0;
      evt_d   = '0;
      fv_d    = 1'b0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_WATCH;
      cnt_q   <= '0;
      decl_q  <= '0;
      info_q  <= '0;
      evt_q   <= '0;
      fv_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      decl_q  <= decl_d;
      info_q  <= info_d;
      evt_q   <= evt_d;
      fv_q    <= fv_d;
      idx_q   <= idx_d;
    end
  end

  assign mon.block           = (state_q == ST_DETECTED);
  assign mon.axis_block_info = info_q;
  assign first_valid         = fv_q;
  assign first_idx           = idx_q;
  assign event_count         = evt_q;

endmodule

// File: tb/tb_axis_deadlock_monitor.sv
// Directed scoreboard bench for axis_deadlock_monitor (NUM_AXIS=3).
module tb_axis_deadlock_monitor;

`ifdef AXIS_DEADLOCK_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        clear;
  logic [7:0]  threshold;
  logic        first_valid;
  logic [4:0]  first_idx;
  logic [15:0] event_count;

  axis_deadlock_monitor_if #(.NUM_AXIS(3)) mon_if ();

  axis_deadlock_monitor #(
    .NUM_AXIS(3), .THRESH_W(8), .EVT_W(16), .IDX_W(5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .mon        (mon_if),
    .threshold  (threshold),
    .first_valid(first_valid),
    .first_idx  (first_idx),
    .event_count(event_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic        blk;
    logic [8:0]  info;
    logic        fv;
    logic [4:0]  idx;
    logic [15:0] evt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic cmp(input string tag, input string fld,
                     input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input string tag, input logic b, input logic [8:0] info,
                      input logic fv, input logic [4:0] idx, input logic [15:0] ev);
    exp_t e;
    e.tag = tag; e.blk = b; e.info = info; e.fv = fv; e.idx = idx; e.evt = ev;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    n_pass++;
    e = sb.pop_front();
    cmp(e.tag, "block", 16'(mon_if.block), 16'(e.blk));
    cmp(e.tag, "info",  16'(mon_if.axis_block_info), 16'(e.info));
    cmp(e.tag, "first_valid", 16'(first_valid), 16'(e.fv));
    cmp(e.tag, "first_idx", 16'(first_idx), 16'(e.idx));
    cmp(e.tag, "event_count", event_count, e.evt);
  endtask

  // Push the expectation for the coming edge, clock it, then compare.
  task automatic step(input string tag, input logic b, input logic [8:0] info,
                      input logic fv, input logic [4:0] idx, input logic [15:0] ev);
    push(tag, b, info, fv, idx, ev);
    tick();
    pop_check();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step("clear", 1'b0, 9'h000, 1'b0, 5'd0, 16'd0);
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; threshold = 8'd1;
    mon_if.axis_block_sigs = 3'b000;
    mon_if.inst_idle_sigs  = 3'b000;
    tick();
    step("reset", 1'b0, 9'h000, 1'b0, 5'd0, 16'd0);
    reset = 1'b0;

    // Single-cycle stall at threshold 1.
    mon_if.axis_block_sigs = 3'b001;
    step("thr1_decl", 1'b1, 9'b000_000_110, 1'b1, 5'd0, 16'd1);
    mon_if.axis_block_sigs = 3'b000;
    step("thr1_rel", STICKY, STICKY ? 9'b000_000_110 : 9'h000, 1'b1, 5'd0, 16'd1);
    do_clear();

    // Threshold 4: short burst ignored, full burst declared.
    threshold = 8'd4;
    mon_if.axis_block_sigs = 3'b100;
    for (int i = 0; i < 3; i++) step("thr4_burst1", 1'b0, 9'h000, 1'b0, 5'd0, 16'd0);
    mon_if.axis_block_sigs = 3'b000;
    step("thr4_gap", 1'b0, 9'h000, 1'b0, 5'd0, 16'd0);
    mon_if.axis_block_sigs = 3'b100;
    for (int i = 0; i < 3; i++) step("thr4_burst2", 1'b0, 9'h000, 1'b0, 5'd0, 16'd0);
    step("thr4_decl", 1'b1, 9'b011_000_000, 1'b1, 5'd2, 16'd1);
    mon_if.axis_block_sigs = 3'b000;
    step("thr4_rel", STICKY, STICKY ? 9'b011_000_000 : 9'h000, 1'b1, 5'd2, 16'd1);
    do_clear();

    // Simultaneous declaration of channels 1 and 2.
    threshold = 8'd2;
    mon_if.axis_block_sigs = 3'b110;
    step("simul_wait", 1'b0, 9'h000, 1'b0, 5'd0, 16'd0);
    step("simul_decl", 1'b1, 9'b011_101_000, 1'b1, 5'd1, 16'd1);
    mon_if.axis_block_sigs = 3'b000;
    step("simul_rel", STICKY, STICKY ? 9'b011_101_000 : 9'h000, 1'b1, 5'd1, 16'd1);
    do_clear();

    // Idle masking, then release of idle.
    mon_if.inst_idle_sigs  = 3'b001;
    mon_if.axis_block_sigs = 3'b001;
    for (int i = 0; i < 10; i++) step("idle_mask", 1'b0, 9'h000, 1'b0, 5'd0, 16'd0);
    mon_if.inst_idle_sigs = 3'b000;
    step("idle_drop1", 1'b0, 9'h000, 1'b0, 5'd0, 16'd0);
    step("idle_drop2", 1'b1, 9'b000_000_110, 1'b1, 5'd0, 16'd1);

    // Clear during an active stall, threshold 3.
    threshold = 8'd3;
    do_clear();
    step("clr_stall1", 1'b0, 9'h000, 1'b0, 5'd0, 16'd0);
    step("clr_stall2", 1'b0, 9'h000, 1'b0, 5'd0, 16'd0);
    step("clr_stall3", 1'b1, 9'b000_000_110, 1'b1, 5'd0, 16'd1);

    // Release, then a second detection event.
    mon_if.axis_block_sigs = 3'b000;
    step("evt_rel", STICKY, STICKY ? 9'b000_000_110 : 9'h000, 1'b1, 5'd0, 16'd1);
    threshold = 8'd1;
    mon_if.axis_block_sigs = 3'b001;
    step("evt_second", 1'b1, 9'b000_000_110, 1'b1, 5'd0, STICKY ? 16'd1 : 16'd2);
    mon_if.axis_block_sigs = 3'b000;
    do_clear();

    // Threshold 0 behaves as 1.
    threshold = 8'd0;
    mon_if.axis_block_sigs = 3'b010;
    step("thr0_decl", 1'b1, 9'b000_101_000, 1'b1, 5'd1, 16'd1);
    mon_if.axis_block_sigs = 3'b000;
    do_clear();

    // Lowering threshold below the running count declares on the next edge.
    threshold = 8'd5;
    mon_if.axis_block_sigs = 3'b001;
    step("thr_low1", 1'b0, 9'h000, 1'b0, 5'd0, 16'd0);
    step("thr_low2", 1'b0, 9'h000, 1'b0, 5'd0, 16'd0);
    threshold = 8'd2;
    step("thr_low_decl", 1'b1, 9'b000_000_110, 1'b1, 5'd0, 16'd1);
    mon_if.axis_block_sigs = 3'b000;
    do_clear();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_deadlock_monitor.md
Name: axis_deadlock_monitor

Overview:
Parametrised per-instance AXI-Stream deadlock monitor for the C/RTL co-simulation deadlock checker. It generalises the fixed 3-channel monitor to NUM_AXIS channels. A stall is reported only after it persists for a programmable number of consecutive cycles, and idle channels are masked out. The block records the first channel to stall and counts detection events. It sits between the per-channel AXIS stall detectors and the top-level deadlock reporter.

Parameters:
NUM_AXIS, 3, number of monitored AXIS channels (1..32)
THRESH_W, 8, width of the persistence threshold and the per-channel stall counters
EVT_W, 16, width of the detection-event counter
IDX_W, 5, width of first_idx (must satisfy 2**IDX_W >= NUM_AXIS)

Ports:
clock  in  1  clock; all logic on the rising edge
reset  in  1  reset, synchronous, active-high
clear  in  1  synchronous soft clear of counters, flags and capture
axis_block_sigs  in  NUM_AXIS  per-channel raw stall indication
inst_idle_sigs  in  NUM_AXIS  per-channel idle; 1 masks the stall
threshold  in  THRESH_W  consecutive stall cycles needed to declare a channel; sampled every cycle
axis_block_info  out  NUM_AXIS*NUM_AXIS  per-channel info slices
block  out  1  deadlock detected
first_valid  out  1  first_idx holds a valid capture
first_idx  out  IDX_W  index of the first declared channel
event_count  out  EVT_W  number of WATCH->DETECTED transitions

Behaviour:
- Reset (reset=1 at an edge): all counters, flags, state and outputs are 0; state = WATCH. clear=1 has the same effect; reset has priority.
- Effective threshold thr_eff = max(threshold, 1).
- Per channel k, act_k = axis_block_sigs[k] & ~inst_idle_sigs[k].
- Counter cnt_k:
  - act_k=1: cnt_k increments by 1, saturating at 2**THRESH_W-1.
  - act_k=0: cnt_k returns to 0.
- Declared flag decl_k is registered: decl_k <= act_k & (cnt_k+1 >= thr_eff), compared in THRESH_W+1 bits.
  - Declaration latency is thr_eff edges. With threshold 1, decl_k rises on the first edge act_k is seen.
  - Deassertion takes 1 edge after act_k falls.
- Info slice [k*NUM_AXIS +: NUM_AXIS] = ~(1<<k) when decl_k=1, else 0. All slices are 0 whenever block=0.
- block = OR of decl_k, taken from registers with no combinational path from the inputs.
- State machine:
  - WATCH -> DETECTED on the edge where any decl_k becomes set. On that edge, event_count increments, saturating at max.
  - DETECTED -> WATCH on the edge where all decl_k are 0.
  - block=1 exactly while in DETECTED.
- First capture:
  - On the first WATCH->DETECTED transition since reset or clear: first_valid<=1 and first_idx<=lowest k with the new decl_k=1.
  - Simultaneous declarations resolve to the lowest index.
  - The capture is sticky until reset or clear.
- clear together with an active stall: the clear wins, all counters restart from 0, and declaration needs thr_eff more edges after clear drops.
- threshold changing mid-stall: takes effect on the next comparison. Lowering it below an existing cnt declares on the next edge.
- Idle asserting mid-stall zeroes cnt_k and decl_k on that edge.

Optional Feature:
AXIS_DEADLOCK_STICKY_EN
- Defined: once DETECTED, the FSM stays there and block remains 1 until reset or clear. decl_k and the info slices also latch (OR-accumulate) until reset or clear.
- Undefined: the non-sticky behaviour above.

Test Plan:
- NUM_AXIS=3, threshold=1, axis_block_sigs=3'b001 for 1 cycle -> next edge: block=1, axis_block_info[2:0]=3'b110, first_idx=0, event_count=1. Edge after sig drops -> block=0, info=0.
- threshold=4, channel 2 stalls 3 cycles, then drops, then stalls 4 cycles -> no block on the first burst. On the 4th edge of the second burst: block=1, info[8:6]=3'b011.
- Channels 1 and 2 both stall from the same cycle, threshold=2 -> both declare on the same edge; first_idx=1, info[5:3]=3'b101 and info[8:6]=3'b011.
- Channel 0 stalls with inst_idle_sigs[0]=1 for 10 cycles, threshold=2 -> block stays 0. Drop idle -> block=1 two edges later.
- Declared state, then clear=1 for 1 cycle while the stall continues, threshold=3 -> block=0, first_valid=0, event_count=0 after the clear edge. block=1 again 3 edges after clear drops.
- Sticky build: stall channel 0, then release it -> block remains 1 and info[2:0]=3'b110 until clear. Non-sticky build: block=0 one edge after release.
